rtc_cfg_ctrl: RTL and testbench

//  Register-mapped configuration sequencer for the RTC clock/date/timer/alarm core.

---
 rtl/rtc_cfg_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_rtc_cfg_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_cfg_ctrl.sv
// rtc_cfg_ctrl: bus-facing configuration sequencer for the RTC core.
// Single-beat reads/writes, one load pulse per config write followed by a
// settle window, coherent clock/date snapshot, sticky maskable interrupt.
module rtc_cfg_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        clock_update_o,
    output logic [21:0] clock_o,
    output logic [9:0]  init_sec_cnt_o,
    output logic        timer_update_o,
    output logic        timer_enable_o,
    output logic        timer_retrig_o,
    output logic [16:0] timer_target_o,
    output logic        alarm_enable_o,
    output logic        alarm_update_o,
    output logic [21:0] alarm_clock_o,
    output logic        date_update_o,
    output logic [31:0] date_o,
    input  logic [21:0] rtc_clock_i,
    input  logic [31:0] rtc_date_i,
    input  logic [16:0] rtc_timer_value_i,
    input  logic [21:0] rtc_alarm_clock_i,
    input  logic        rtc_event_i,
    input  logic        rtc_update_day_i,
    output logic        irq_o
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [2:0] A_CLOCK  = 3'd0;
    localparam logic [2:0] A_DATE   = 3'd1;
    localparam logic [2:0] A_ALARM  = 3'd2;
    localparam logic [2:0] A_TIMER  = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    // pulse vector bit positions
    localparam int P_CLOCK = 0;
    localparam int P_DATE  = 1;
    localparam int P_ALARM = 2;
    localparam int P_TIMER = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [21:0]   clock_q, clock_d;
    logic [31:0]   date_q, date_d;
    logic [21:0]   alarm_q, alarm_d;
    logic [16:0]   timer_q, timer_d;
    logic          alarm_en_q, alarm_en_d;
    logic          timer_en_q, timer_en_d;
    logic          retrig_q, retrig_d;
    logic          irq_en_q, irq_en_d;
    logic [9:0]    init_q, init_d;
    logic          pending_q, pending_d;
    logic          irq_q, irq_d;
    logic [31:0]   snap_date_q, snap_date_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic gnt;
    logic clk_rd_hold;
    logic w1c;

    // Grant: only in IDLE; a CLOCK read is held off during a day rollover so
    // the captured clock and date belong to the same day.
    always_comb begin
        clk_rd_hold = req_i & ~we_i & (addr_i == A_CLOCK) & rtc_update_day_i;
        gnt         = ~rst_i & (state_q == S_IDLE) & req_i & ~clk_rd_hold;
        w1c         = gnt & we_i & (addr_i == A_STATUS) & wdata_i[0];
    end

    // Next-state, register loads, read mux and event/interrupt tracking
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = '0;
        clock_d     = clock_q;
        date_d      = date_q;
        alarm_d     = alarm_q;
        timer_d     = timer_q;
        alarm_en_d  = alarm_en_q;
        timer_en_d  = timer_en_q;
        retrig_d    = retrig_q;
        irq_en_d    = irq_en_q;
        init_d      = init_q;
        snap_date_d = snap_date_q;
        rvalid_d    = gnt;
        err_d       = gnt & addr_i[2] & addr_i[1];
        rdata_d     = '0;
        // event set takes priority over a concurrent W1C
        pending_d   = rtc_event_i | (pending_q & ~w1c);

        case (state_q)
            S_IDLE: begin
                if (gnt && we_i) begin
                    case (addr_i)
                        A_CLOCK: begin
                            clock_d          = wdata_i[21:0];
                            pulse_d[P_CLOCK] = 1'b1;
                            state_d          = S_APPLY;
                        end
                        A_DATE: begin
                            date_d          = wdata_i;
                            pulse_d[P_DATE] = 1'b1;
                            state_d         = S_APPLY;
                        end
                        A_ALARM: begin
                            alarm_d          = wdata_i[21:0];
                            pulse_d[P_ALARM] = 1'b1;
                            state_d          = S_APPLY;
                        end
                        A_TIMER: begin
                            timer_d          = wdata_i[16:0];
                            pulse_d[P_TIMER] = 1'b1;
                            state_d          = S_APPLY;
                        end
                        A_CTRL: begin
                            alarm_en_d       = wdata_i[0];
                            timer_en_d       = wdata_i[1];
                            retrig_d         = wdata_i[2];
                            irq_en_d         = wdata_i[3];
                            init_d           = wdata_i[13:4];
                            pulse_d[P_TIMER] = 1'b1;
                            state_d          = S_APPLY;
                        end
                        default: ; // STATUS handled by w1c; 6/7 have no effect
                    endcase
                end else if (gnt) begin
                    case (addr_i)
                        A_CLOCK: begin
                            rdata_d     = {10'd0, rtc_clock_i};
                            snap_date_d = rtc_date_i;
                        end
                        A_DATE:   rdata_d = snap_date_q;
                        A_ALARM:  rdata_d = {10'd0, rtc_alarm_clock_i};
                        A_TIMER:  rdata_d = {15'd0, rtc_timer_value_i};
                        A_CTRL:   rdata_d = {18'd0, init_q, irq_en_q, retrig_q,
                                             timer_en_q, alarm_en_q};
                        A_STATUS: rdata_d = {31'd0, pending_q};
                        default:  rdata_d = '0;
                    endcase
                end
            end
            S_APPLY: begin
                state_d = S_SETTLE;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        irq_d = pending_d & irq_en_d;
    end

    // State and data registers, synchronous reset clears everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pulse_q     <= '0;
            clock_q     <= '0;
            date_q      <= '0;
            alarm_q     <= '0;
            timer_q     <= '0;
            alarm_en_q  <= 1'b0;
            timer_en_q  <= 1'b0;
            retrig_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            init_q      <= '0;
            pending_q   <= 1'b0;
            irq_q       <= 1'b0;
            snap_date_q <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            clock_q     <= clock_d;
            date_q      <= date_d;
            alarm_q     <= alarm_d;
            timer_q     <= timer_d;
            alarm_en_q  <= alarm_en_d;
            timer_en_q  <= timer_en_d;
            retrig_q    <= retrig_d;
            irq_en_q    <= irq_en_d;
            init_q      <= init_d;
            pending_q   <= pending_d;
            irq_q       <= irq_d;
            snap_date_q <= snap_date_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign gnt_o          = gnt;
    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign err_o          = err_q;
    assign clock_update_o = pulse_q[P_CLOCK];
    assign date_update_o  = pulse_q[P_DATE];
    assign alarm_update_o = pulse_q[P_ALARM];
    assign timer_update_o = pulse_q[P_TIMER];
    assign clock_o        = clock_q;
    assign date_o         = date_q;
    assign alarm_clock_o  = alarm_q;
    assign timer_target_o = timer_q;
    assign alarm_enable_o = alarm_en_q;
    assign timer_enable_o = timer_en_q;
    assign timer_retrig_o = retrig_q;
    assign init_sec_cnt_o = init_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_cfg_ctrl.sv
// Bench for rtc_cfg_ctrl: directed cases with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_rtc_cfg_ctrl;

    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst, req, we, ev, upd_day;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [21:0] rtc_clock, rtc_alarm;
    logic [31:0] rtc_date;
    logic [16:0] rtc_timer;

    logic        gnt_o, rvalid_o, err_o, irq_o;
    logic [31:0] rdata_o, date_o;
    logic        clock_update_o, timer_update_o, alarm_update_o, date_update_o;
    logic [21:0] clock_o, alarm_clock_o;
    logic [9:0]  init_sec_cnt_o;
    logic        timer_enable_o, timer_retrig_o, alarm_enable_o;
    logic [16:0] timer_target_o;

    int checks = 0;
    int errors = 0;

    rtc_cfg_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .clock_update_o(clock_update_o), .clock_o(clock_o),
        .init_sec_cnt_o(init_sec_cnt_o), .timer_update_o(timer_update_o),
        .timer_enable_o(timer_enable_o), .timer_retrig_o(timer_retrig_o),
        .timer_target_o(timer_target_o), .alarm_enable_o(alarm_enable_o),
        .alarm_update_o(alarm_update_o), .alarm_clock_o(alarm_clock_o),
        .date_update_o(date_update_o), .date_o(date_o),
        .rtc_clock_i(rtc_clock), .rtc_date_i(rtc_date),
        .rtc_timer_value_i(rtc_timer), .rtc_alarm_clock_i(rtc_alarm),
        .rtc_event_i(ev), .rtc_update_day_i(upd_day), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [21:0] m_clock, m_alarm;
    logic [31:0] m_date, m_snap, m_rdata;
    logic [16:0] m_timer;
    logic [9:0]  m_init;
    logic        m_alarm_en, m_timer_en, m_retrig, m_irq_en;
    logic        m_pending, m_irq, m_rvalid, m_err;
    logic [3:0]  m_pulse;   // {timer, alarm, date, clock}
    int          m_block;   // cycles during which no new grant may happen
    bit          chk_en = 0;

    function automatic logic exp_gnt();
        if (rst || m_block != 0) return 1'b0;
        if (req && !we && addr == 3'd0 && upd_day) return 1'b0;
        return req;
    endfunction

    task automatic model_step();
        logic g;
        g = exp_gnt();
        if (rst) begin
            m_clock = '0; m_alarm = '0; m_date = '0; m_snap = '0; m_rdata = '0;
            m_timer = '0; m_init = '0; m_alarm_en = 0; m_timer_en = 0;
            m_retrig = 0; m_irq_en = 0; m_pending = 0; m_irq = 0;
            m_rvalid = 0; m_err = 0; m_pulse = '0; m_block = 0;
            chk_en = 1;
            return;
        end
        if (m_block > 0) m_block--;
        m_pulse  = '0;
        m_rvalid = g;
        m_err    = g && (addr >= 3'd6);
        m_rdata  = '0;
        if (g && !we) begin
            case (addr)
                3'd0: m_rdata = {10'd0, rtc_clock};
                3'd1: m_rdata = m_snap;
                3'd2: m_rdata = {10'd0, rtc_alarm};
                3'd3: m_rdata = {15'd0, rtc_timer};
                3'd4: m_rdata = {18'd0, m_init, m_irq_en, m_retrig, m_timer_en, m_alarm_en};
                3'd5: m_rdata = {31'd0, m_pending};
                default: m_rdata = '0;
            endcase
            if (addr == 3'd0) m_snap = rtc_date;
        end
        if (g && we && addr <= 3'd4) begin
            m_block = 1 + SETTLE;
            case (addr)
                3'd0: begin m_clock = wdata[21:0]; m_pulse[0] = 1; end
                3'd1: begin m_date  = wdata;       m_pulse[1] = 1; end
                3'd2: begin m_alarm = wdata[21:0]; m_pulse[2] = 1; end
                3'd3: begin m_timer = wdata[16:0]; m_pulse[3] = 1; end
                default: begin
                    m_alarm_en = wdata[0]; m_timer_en = wdata[1];
                    m_retrig   = wdata[2]; m_irq_en   = wdata[3];
                    m_init     = wdata[13:4];
                    m_pulse[3] = 1;
                end
            endcase
        end
        m_pending = ev || (m_pending && !(g && we && addr == 3'd5 && wdata[0]));
        m_irq     = m_pending && m_irq_en;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst) chk("gnt", gnt_o, exp_gnt());
            chk("rvalid", rvalid_o, m_rvalid);
            chk("rdata", rdata_o, m_rdata);
            chk("err", err_o, m_err);
            chk("clock_update", clock_update_o, m_pulse[0]);
            chk("date_update", date_update_o, m_pulse[1]);
            chk("alarm_update", alarm_update_o, m_pulse[2]);
            chk("timer_update", timer_update_o, m_pulse[3]);
            chk("clock", clock_o, m_clock);
            chk("date", date_o, m_date);
            chk("alarm_clock", alarm_clock_o, m_alarm);
            chk("timer_target", timer_target_o, m_timer);
            chk("ctrl", {init_sec_cnt_o, timer_retrig_o, timer_enable_o, alarm_enable_o},
                {m_init, m_retrig, m_timer_en, m_alarm_en});
            chk("irq", irq_o, m_irq);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        req = r; we = w; addr = a; wdata = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; ev = 0; upd_day = 0;
        drive(0, 0, 3'd0, 32'd0);
        rtc_clock = '0; rtc_alarm = '0; rtc_date = '0; rtc_timer = '0;
        tick(); tick();
        rst = 0;
        chk("rst_irq", irq_o, 0);
        chk("rst_clock", clock_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        drive(1, 0, 3'd3, 32'd0); #1;
        chk("rst_gnt_follows_req", gnt_o, 1);
        tick(); drive(0, 0, 3'd0, 32'd0);

        // CLOCK write, held request: pulse at N+1, next grant at N+3
        drive(1, 1, 3'd0, 32'h12345); #1;
        chk("wclk_gnt_N", gnt_o, 1);
        tick();
        chk("wclk_value", clock_o, 32'h12345);
        chk("wclk_pulse_N1", clock_update_o, 1);
        chk("wclk_gnt_N1", gnt_o, 0);
        tick();
        chk("wclk_pulse_N2", clock_update_o, 0);
        chk("wclk_gnt_N2", gnt_o, 0);
        tick();
        chk("wclk_gnt_N3", gnt_o, 1);
        drive(0, 0, 3'd0, 32'd0);
        tick(); tick();

        // CTRL write
        drive(1, 1, 3'd4, 32'h0000_0ABF);
        tick(); drive(0, 0, 3'd0, 32'd0);
        chk("ctrl_alarm_en", alarm_enable_o, 1);
        chk("ctrl_timer_en", timer_enable_o, 1);
        chk("ctrl_retrig", timer_retrig_o, 1);
        chk("ctrl_init", init_sec_cnt_o, 32'h0AB);
        chk("ctrl_pulse", timer_update_o, 1);
        tick();
        chk("ctrl_pulse_once", timer_update_o, 0);
        tick(); tick();

        // CLOCK read during day rollover is deferred, snapshot gets new date
        rtc_clock = 22'h2AAAA; rtc_date = 32'h1111_1111; upd_day = 1;
        drive(1, 0, 3'd0, 32'd0); #1;
        chk("defer_gnt_low", gnt_o, 0);
        tick();
        upd_day = 0; rtc_date = 32'h1111_1112; #1;
        chk("defer_gnt_high", gnt_o, 1);
        tick();
        chk("rclk_rvalid", rvalid_o, 1);
        chk("rclk_rdata", rdata_o, 32'h2AAAA);
        addr = 3'd1;
        tick(); drive(0, 0, 3'd0, 32'd0);
        chk("rdate_snapshot", rdata_o, 32'h1111_1112);

        // interrupt: set, W1C, set-wins
        ev = 1; tick(); ev = 0;
        chk("irq_set", irq_o, 1);
        drive(1, 1, 3'd5, 32'h1); tick(); drive(0, 0, 3'd0, 32'd0);
        chk("irq_w1c", irq_o, 0);
        ev = 1; tick();
        drive(1, 1, 3'd5, 32'h1); tick(); drive(0, 0, 3'd0, 32'd0); ev = 0;
        chk("irq_set_wins", irq_o, 1);

        // unmapped read
        drive(1, 0, 3'd6, 32'd0); tick(); drive(0, 0, 3'd0, 32'd0);
        chk("unmap_rvalid", rvalid_o, 1);
        chk("unmap_err", err_o, 1);
        chk("unmap_rdata", rdata_o, 0);
        chk("unmap_no_pulse", {clock_update_o, date_update_o, alarm_update_o, timer_update_o}, 0);

        // reset while settling
        drive(1, 1, 3'd0, 32'h3FFFF); tick(); drive(0, 0, 3'd0, 32'd0);
        tick();
        rst = 1; tick(); rst = 0;
        chk("rst_settle_clock", clock_o, 0);
        drive(1, 0, 3'd3, 32'd0); #1;
        chk("rst_settle_idle", gnt_o, 1);
        tick(); drive(0, 0, 3'd0, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            req       = $urandom_range(0, 1) == 1;
            we        = $urandom_range(0, 1) == 1;
            addr      = 3'($urandom_range(0, 7));
            wdata     = $urandom;
            ev        = ($urandom_range(0, 9) == 0);
            upd_day   = ($urandom_range(0, 7) == 0);
            rtc_clock = 22'($urandom);
            rtc_date  = $urandom;
            rtc_alarm = 22'($urandom);
            rtc_timer = 17'($urandom);
            tick();
        end
        rst = 0; drive(0, 0, 3'd0, 32'd0); ev = 0; upd_day = 0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
